// File: rtl/wshb_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wshb_if
//  Brief    : Wishbone bus bundle shared by the arbiter, its masters and the
//             SDRAM slave port.
//  Revision : 1.0 - initial release
// ============================================================================
interface wshb_if #(
    parameter int DATA_BYTES = 4
) ();
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [31:0]               adr;
    logic [8*DATA_BYTES-1:0]   dat_ms;
    logic [8*DATA_BYTES-1:0]   dat_sm;
    logic [DATA_BYTES-1:0]     sel;
    logic [2:0]                cti;
    logic [1:0]                bte;
    logic                      ack;
    logic                      err;
    logic                      rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, err, rty, dat_sm
    );
endinterface
`default_nettype wire

// File: rtl/wshb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wshb_rr_arbiter
//  Brief    : 3-master / 1-slave Wishbone round-robin arbiter with a per-grant
//             ack quota. Define ARB_STATS_EN for per-master ack counters.
//  Revision : 1.0 - initial release
// ============================================================================
module wshb_rr_arbiter #(
    parameter int MAX_BURST  = 64,
    parameter int DATA_BYTES = 4
) (
    input  wire logic   sys_clk,
    input  wire logic   sys_rst,
    wshb_if.slave       wshb_ifs_0,
    wshb_if.slave       wshb_ifs_1,
    wshb_if.slave       wshb_ifs_2,
    wshb_if.master      wshb_ifm,
    output logic [2:0]  grant,
    output logic [15:0] ack_cnt_0,
    output logic [15:0] ack_cnt_1,
    output logic [15:0] ack_cnt_2
);

    localparam int               c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_BURST);
    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_OWN  = 2'd1;
    localparam logic [1:0]       c_ST_GAP  = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [2:0]              r_grant;
    logic [2:0]              w_grant_nxt;
    logic [1:0]              r_last;
    logic [1:0]              w_last_nxt;
    logic [c_CNT_W-1:0]      r_burst_cnt;
    logic                    w_cnt_clr;

    logic [2:0]              w_req;
    logic [1:0]              w_pick;
    logic                    w_pick_valid;
    logic                    w_force;
    logic                    w_pass;
    logic                    w_ack_dlv;

    logic                    w_m_cyc;
    logic                    w_m_stb;
    logic                    w_m_we;
    logic [31:0]             w_m_adr;
    logic [8*DATA_BYTES-1:0] w_m_dat_ms;
    logic [DATA_BYTES-1:0]   w_m_sel;
    logic [2:0]              w_m_cti;
    logic [1:0]              w_m_bte;

    assign w_req = {wshb_ifs_2.cyc, wshb_ifs_1.cyc, wshb_ifs_0.cyc};

    // r_last doubles as the owner index while in OWN
    always_comb begin
        w_m_cyc    = wshb_ifs_0.cyc;
        w_m_stb    = wshb_ifs_0.stb;
        w_m_we     = wshb_ifs_0.we;
        w_m_adr    = wshb_ifs_0.adr;
        w_m_dat_ms = wshb_ifs_0.dat_ms;
        w_m_sel    = wshb_ifs_0.sel;
        w_m_cti    = wshb_ifs_0.cti;
        w_m_bte    = wshb_ifs_0.bte;
        case (r_last)
            2'd1: begin
                w_m_cyc    = wshb_ifs_1.cyc;
                w_m_stb    = wshb_ifs_1.stb;
                w_m_we     = wshb_ifs_1.we;
                w_m_adr    = wshb_ifs_1.adr;
                w_m_dat_ms = wshb_ifs_1.dat_ms;
                w_m_sel    = wshb_ifs_1.sel;
                w_m_cti    = wshb_ifs_1.cti;
                w_m_bte    = wshb_ifs_1.bte;
            end
            2'd2: begin
                w_m_cyc    = wshb_ifs_2.cyc;
                w_m_stb    = wshb_ifs_2.stb;
                w_m_we     = wshb_ifs_2.we;
                w_m_adr    = wshb_ifs_2.adr;
                w_m_dat_ms = wshb_ifs_2.dat_ms;
                w_m_sel    = wshb_ifs_2.sel;
                w_m_cti    = wshb_ifs_2.cti;
                w_m_bte    = wshb_ifs_2.bte;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_pick_valid = |w_req;
        w_pick       = 2'd0;
        case (r_last)
            2'd0:    w_pick = w_req[1] ? 2'd1 : (w_req[2] ? 2'd2 : 2'd0);
            2'd1:    w_pick = w_req[2] ? 2'd2 : (w_req[0] ? 2'd0 : 2'd1);
            default: w_pick = w_req[0] ? 2'd0 : (w_req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Quota release only in an ack-free cycle so no transfer is split
    assign w_force   = (r_state == c_ST_OWN) && w_m_cyc && (r_burst_cnt == c_MAX)
                       && (|(w_req & ~r_grant)) && !wshb_ifm.ack;
    assign w_pass    = (r_state == c_ST_OWN) && !w_force;
    assign w_ack_dlv = w_pass && wshb_ifm.ack;

    assign wshb_ifm.cyc    = w_pass && w_m_cyc;
    assign wshb_ifm.stb    = w_pass && w_m_stb;
    assign wshb_ifm.we     = w_m_we;
    assign wshb_ifm.adr    = w_m_adr;
    assign wshb_ifm.dat_ms = w_m_dat_ms;
    assign wshb_ifm.sel    = w_m_sel;
    assign wshb_ifm.cti    = w_m_cti;
    assign wshb_ifm.bte    = w_m_bte;

    assign wshb_ifs_0.ack    = w_pass && r_grant[0] && wshb_ifm.ack;
    assign wshb_ifs_0.err    = w_pass && r_grant[0] && wshb_ifm.err;
    assign wshb_ifs_0.rty    = w_pass && r_grant[0] && wshb_ifm.rty;
    assign wshb_ifs_0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs_1.ack    = w_pass && r_grant[1] && wshb_ifm.ack;
    assign wshb_ifs_1.err    = w_pass && r_grant[1] && wshb_ifm.err;
    assign wshb_ifs_1.rty    = w_pass && r_grant[1] && wshb_ifm.rty;
    assign wshb_ifs_1.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs_2.ack    = w_pass && r_grant[2] && wshb_ifm.ack;
    assign wshb_ifs_2.err    = w_pass && r_grant[2] && wshb_ifm.err;
    assign wshb_ifs_2.rty    = w_pass && r_grant[2] && wshb_ifm.rty;
    assign wshb_ifs_2.dat_sm = wshb_ifm.dat_sm;

    assign grant = r_grant;

    // GAP arbitrates directly so the dead cycle is exactly one clock
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_cnt_clr   = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_GAP: begin
                if (w_pick_valid) begin
                    w_state_nxt = c_ST_OWN;
                    w_grant_nxt = 3'b001 << w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                    w_grant_nxt = 3'b000;
                end
            end
            c_ST_OWN: begin
                if (!w_m_cyc || w_force) begin
                    w_state_nxt = c_ST_GAP;
                    w_grant_nxt = 3'b000;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = 3'b000;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= 3'b000;
            r_last      <= 2'd2;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            if (w_cnt_clr) begin
                r_burst_cnt <= '0;
            end else if (w_ack_dlv && (r_burst_cnt != c_MAX)) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    for (genvar gi = 0; gi < 3; gi++) begin : g_stats
        logic [15:0] r_ack_cnt;
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                r_ack_cnt <= 16'h0000;
            end else if (w_ack_dlv && r_grant[gi] && (r_ack_cnt != 16'hFFFF)) begin
                r_ack_cnt <= r_ack_cnt + 16'h0001;
            end
        end
    end
    assign ack_cnt_0 = g_stats[0].r_ack_cnt;
    assign ack_cnt_1 = g_stats[1].r_ack_cnt;
    assign ack_cnt_2 = g_stats[2].r_ack_cnt;
`else
    assign ack_cnt_0 = 16'h0000;
    assign ack_cnt_1 = 16'h0000;
    assign ack_cnt_2 = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wshb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wshb_rr_arbiter
//  Brief    : Scoreboard bench for wshb_rr_arbiter (MAX_BURST = 8), with a
//             registered ack-every-other-cycle slave and burst masters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wshb_rr_arbiter;

    typedef struct {
        logic [2:0] grant;
        int         acks;
        int         gap;
    } own_t;

    logic        sys_clk;
    logic        sys_rst;
    logic [2:0]  grant;
    logic [15:0] ack_cnt_0, ack_cnt_1, ack_cnt_2;

    logic [2:0]  m_cyc, m_stb, m_abort;
    logic [31:0] m_adr [3];
    logic        s_ack, s_ack_nxt;
    logic [2:0]  ack_m;

    int          n_checks, n_fail;
    int          ack_seen [3];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    own_t        exp_own [$];

    wshb_if #(.DATA_BYTES(4)) if_m0 ();
    wshb_if #(.DATA_BYTES(4)) if_m1 ();
    wshb_if #(.DATA_BYTES(4)) if_m2 ();
    wshb_if #(.DATA_BYTES(4)) if_s  ();

    assign if_m0.cyc = m_cyc[0];  assign if_m0.stb = m_stb[0];  assign if_m0.adr = m_adr[0];
    assign if_m1.cyc = m_cyc[1];  assign if_m1.stb = m_stb[1];  assign if_m1.adr = m_adr[1];
    assign if_m2.cyc = m_cyc[2];  assign if_m2.stb = m_stb[2];  assign if_m2.adr = m_adr[2];
    assign if_m0.we = 1'b1;  assign if_m0.dat_ms = ~m_adr[0];  assign if_m0.sel = 4'hF;
    assign if_m1.we = 1'b1;  assign if_m1.dat_ms = ~m_adr[1];  assign if_m1.sel = 4'hF;
    assign if_m2.we = 1'b1;  assign if_m2.dat_ms = ~m_adr[2];  assign if_m2.sel = 4'hF;
    assign if_m0.cti = 3'b000;  assign if_m0.bte = 2'b00;
    assign if_m1.cti = 3'b000;  assign if_m1.bte = 2'b00;
    assign if_m2.cti = 3'b000;  assign if_m2.bte = 2'b00;
    assign if_s.ack    = s_ack;
    assign if_s.err    = 1'b0;
    assign if_s.rty    = 1'b0;
    assign if_s.dat_sm = 32'hCAFE_0000;
    assign ack_m = {if_m2.ack, if_m1.ack, if_m0.ack};

    wshb_rr_arbiter #(.MAX_BURST(8), .DATA_BYTES(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wshb_ifs_0 (if_m0),
        .wshb_ifs_1 (if_m1),
        .wshb_ifs_2 (if_m2),
        .wshb_ifm   (if_s),
        .grant      (grant),
        .ack_cnt_0  (ack_cnt_0),
        .ack_cnt_1  (ack_cnt_1),
        .ack_cnt_2  (ack_cnt_2)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Registered slave: acks the cycle after each accepted strobe
    initial begin
        s_ack = 1'b0;
        forever begin
            @(negedge sys_clk);
            s_ack_nxt = !sys_rst && if_s.cyc && if_s.stb && !s_ack;
            @(posedge sys_clk);
            #1 s_ack = s_ack_nxt;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [31:0] a);
        case (id)
            2'd0:    q0.push_back(a);
            2'd1:    q1.push_back(a);
            default: q2.push_back(a);
        endcase
    endtask

    task automatic pop_exp(input logic [1:0] id, output logic ok, output logic [31:0] a);
        ok = 1'b0;
        a  = 32'h0;
        case (id)
            2'd0:    if (q0.size() > 0) begin a = q0.pop_front(); ok = 1'b1; end
            2'd1:    if (q1.size() > 0) begin a = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin a = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic push_own(input logic [2:0] g, input int a, input int gp);
        own_t r;
        r.grant = g;
        r.acks  = a;
        r.gap   = gp;
        exp_own.push_back(r);
    endtask

    task automatic run_master(input logic [1:0] id, input int n, input logic [31:0] base);
        int done;
        int budget;
        done   = 0;
        budget = 0;
        @(posedge sys_clk);
        #1;
        m_cyc[id] = 1'b1;
        m_stb[id] = 1'b1;
        m_adr[id] = base;
        push_exp(id, base);
        while (done < n && budget < 4000 && !m_abort[id]) begin
            @(negedge sys_clk);
            budget++;
            if (ack_m[id]) begin
                done++;
                @(posedge sys_clk);
                #1;
                if (done < n) begin
                    m_adr[id] = base + done;
                    push_exp(id, m_adr[id]);
                end else begin
                    m_cyc[id] = 1'b0;
                    m_stb[id] = 1'b0;
                end
            end
        end
        if (!m_abort[id]) check("master_done", done, n);
        m_cyc[id] = 1'b0;
        m_stb[id] = 1'b0;
    endtask

    task automatic wait_acks(input logic [1:0] id, input int n);
        int b;
        b = 0;
        while (ack_seen[id] < n && b < 1000) begin
            @(posedge sys_clk);
            b++;
        end
        check("wait_acks", (ack_seen[id] >= n) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) ack_seen[i] = 0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    // Monitor: ownership records and per-ack address scoreboard
    initial begin : monitor
        own_t        cur;
        logic        cur_valid;
        int          own_acks;
        int          gap_cnt;
        logic [2:0]  prev_grant;
        logic        ok;
        logic [31:0] a;
        logic [1:0]  idx;
        cur_valid  = 1'b0;
        own_acks   = 0;
        gap_cnt    = 0;
        prev_grant = 3'b000;
        forever begin
            @(negedge sys_clk);
            if (grant !== prev_grant) begin
                if (cur_valid) begin
                    check("own_acks", own_acks, cur.acks);
                    cur_valid = 1'b0;
                end
                if (grant != 3'b000) begin
                    if (exp_own.size() == 0) begin
                        check("grant_unexpected", grant, 3'b000);
                    end else begin
                        cur = exp_own.pop_front();
                        cur_valid = 1'b1;
                        check("own_grant", grant, cur.grant);
                        if (cur.gap >= 0) check("own_gap", gap_cnt, cur.gap);
                        own_acks = 0;
                    end
                end else begin
                    gap_cnt = 0;
                end
            end
            if (grant == 3'b000) gap_cnt++;
            for (int i = 0; i < 3; i++) begin
                idx = 2'(i);
                if (ack_m[idx]) begin
                    pop_exp(idx, ok, a);
                    if (!ok) begin
                        check("ack_unexpected", ack_m, 3'b000);
                    end else begin
                        check("ack_adr", if_s.adr, a);
                        check("ack_owner", grant[idx], 1'b1);
                    end
                    own_acks++;
                    ack_seen[idx]++;
                end
            end
            prev_grant = grant;
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sys_rst  = 1'b1;
        m_cyc    = 3'b000;
        m_stb    = 3'b000;
        m_abort  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m_adr[i]    = 32'h0;
            ack_seen[i] = 0;
        end
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_grant", grant, 3'b000);
        check("rst_cyc", if_s.cyc, 1'b0);
        check("rst_stb", if_s.stb, 1'b0);
        check("rst_acks", ack_m, 3'b000);
        check("rst_stats", {ack_cnt_0, ack_cnt_1, ack_cnt_2}, 48'h0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // Master 0 alone, 10 single writes, one-cycle request latency
        push_own(3'b001, 10, -1);
        fork
            run_master(2'd0, 10, 32'h0000_1000);
            begin
                @(posedge sys_clk);
                @(negedge sys_clk);
                check("lat_cyc_early", if_s.cyc, 1'b0);
                @(negedge sys_clk);
                check("lat_cyc", if_s.cyc, 1'b1);
                check("lat_grant", grant, 3'b001);
            end
        join
        repeat (4) @(negedge sys_clk);
        check("idle_grant", grant, 3'b000);
        check("idle_cyc", if_s.cyc, 1'b0);

        // All three requesting, 4-ack bursts
        do_reset();
        push_own(3'b001, 4, -1);
        push_own(3'b010, 4, 1);
        push_own(3'b100, 4, 1);
        push_own(3'b001, 4, 1);
        fork
            begin
                run_master(2'd0, 4, 32'h0000_1100);
                run_master(2'd0, 4, 32'h0000_1200);
            end
            run_master(2'd1, 4, 32'h0000_2100);
            run_master(2'd2, 4, 32'h0000_3100);
        join
        repeat (4) @(negedge sys_clk);

        // Quota: master 1 long burst, master 0 joins after 3 acks
        do_reset();
        push_own(3'b010, 8, -1);
        push_own(3'b001, 5, 1);
        push_own(3'b010, 92, 1);
        fork
            run_master(2'd1, 100, 32'h0000_2000);
            begin
                wait_acks(2'd1, 3);
                run_master(2'd0, 5, 32'h0000_1000);
            end
        join
        repeat (4) @(negedge sys_clk);

        // Lone master saturates the counter and keeps ownership
        do_reset();
        push_own(3'b100, 50, -1);
        run_master(2'd2, 50, 32'h0000_3000);
        repeat (4) @(negedge sys_clk);

        // Asynchronous reset while master 1 owns the bus
        do_reset();
        push_own(3'b010, 3, -1);
        fork
            run_master(2'd1, 20, 32'h0000_2000);
            begin
                wait_acks(2'd1, 3);
                @(negedge sys_clk);
                #2 sys_rst = 1'b1;
                #1;
                check("arst_grant", grant, 3'b000);
                check("arst_cyc", if_s.cyc, 1'b0);
                check("arst_ack", ack_m, 3'b000);
                m_abort[1] = 1'b1;
            end
        join
        q1.delete();
        m_abort = 3'b000;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        push_own(3'b001, 2, -1);
        push_own(3'b010, 2, 1);
        push_own(3'b100, 2, 1);
        fork
            run_master(2'd0, 2, 32'h0000_1000);
            run_master(2'd1, 2, 32'h0000_2000);
            run_master(2'd2, 2, 32'h0000_3000);
        join
        repeat (4) @(negedge sys_clk);

        // Statistics counters
        do_reset();
        push_own(3'b001, 5, -1);
        push_own(3'b100, 7, 1);
        fork
            run_master(2'd0, 5, 32'h0000_1000);
            run_master(2'd2, 7, 32'h0000_3000);
        join
        repeat (3) @(negedge sys_clk);
`ifdef ARB_STATS_EN
        check("stats_0", ack_cnt_0, 16'd5);
        check("stats_1", ack_cnt_1, 16'd0);
        check("stats_2", ack_cnt_2, 16'd7);
`else
        check("stats_0", ack_cnt_0, 16'd0);
        check("stats_1", ack_cnt_1, 16'd0);
        check("stats_2", ack_cnt_2, 16'd0);
`endif

        check("pending_own", exp_own.size(), 0);
        check("pending_q", q0.size() + q1.size() + q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
